// File: rtl/pila_pkg.sv
// ---------------------------------------------------------------------------
// pila_pkg
//   Shared definitions for the parametric LIFO stack.
//   - OP_* : operation codes decoded from {push, pop}
//   - clog2: ceiling log2, usable in parameter expressions on tools that
//            lack a reliable $clog2
// ---------------------------------------------------------------------------
package pila_pkg;

    // Operation codes, indexed by {push, pop}
    localparam logic [1:0] OP_NADA      = 2'b00;
    localparam logic [1:0] OP_POP       = 2'b01;
    localparam logic [1:0] OP_PUSH      = 2'b10;
    localparam logic [1:0] OP_REEMPLAZA = 2'b11;

    // Smallest n such that 2**n >= value (clog2(1) == 0)
    function automatic int clog2(input int value);
        int res;
        res = 0;
        while ((1 << res) < value) begin
            res = res + 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/pila_mem.sv
// ---------------------------------------------------------------------------
// pila_mem
//   DEPTH x DATA register file backing the stack.
//   Ports:
//     clk          in   system clock, write on posedge
//     i_we         in   write enable
//     i_waddr      in   write index
//     i_wdata      in   write data
//     i_raddr_top  in   read index of the top entry
//     i_raddr_sub  in   read index of the entry below the top
//     o_top        out  combinational read of i_raddr_top
//     o_sub        out  combinational read of i_raddr_sub
// ---------------------------------------------------------------------------
module pila_mem
    import pila_pkg::*;
#(
    parameter int DATA  = 8,
    parameter int DEPTH = 64,
    parameter int AW    = clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            i_we,
    input  logic [AW-1:0]   i_waddr,
    input  logic [DATA-1:0] i_wdata,
    input  logic [AW-1:0]   i_raddr_top,
    input  logic [AW-1:0]   i_raddr_sub,
    output logic [DATA-1:0] o_top,
    output logic [DATA-1:0] o_sub
);

    logic [DATA-1:0] r_mem [DEPTH];

    // NOTE: storage arrays are deliberately left without reset; the occupancy
    // counter defines which entries are valid, so stale contents are harmless
    // and the array maps onto plain flops/RAM without a reset tree.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_top = r_mem[i_raddr_top];
    assign o_sub = r_mem[i_raddr_sub];

endmodule

// File: rtl/pila_parametrica.sv
// ---------------------------------------------------------------------------
// pila_parametrica
//   Parametric LIFO stack with occupancy count, full/empty flags, guarded
//   overflow/underflow with sticky error flags and push+pop "replace top".
//   One operation per clock; every output is registered.
//   Ports:
//     clk             in   system clock
//     reset           in   synchronous active-high reset
//     activa          in   operation enable (0 = hold all state)
//     push, pop       in   operation request, qualified by activa
//     limpia_error    in   clears the sticky error flags (a new error wins)
//     entradaDatos    in   word to push / replace top with
//     salidaDatos     out  top of stack, 0 when empty
//     ocupacion       out  number of stored entries (0..DEPTH)
//     vacia, llena    out  ocupacion == 0 / ocupacion == DEPTH
//     err_desborde    out  sticky: push attempted while full
//     err_subdesborde out  sticky: pop attempted while empty
// ---------------------------------------------------------------------------
module pila_parametrica
    import pila_pkg::*;
#(
    parameter  int DATA  = 8,
    parameter  int DEPTH = 64,
    localparam int CNT_W = clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             activa,
    input  logic             push,
    input  logic             pop,
    input  logic             limpia_error,
    input  logic [DATA-1:0]  entradaDatos,
    output logic [DATA-1:0]  salidaDatos,
    output logic [CNT_W-1:0] ocupacion,
    output logic             vacia,
    output logic             llena,
    output logic             err_desborde,
    output logic             err_subdesborde
);

    localparam int              AW      = clog2(DEPTH);
    localparam logic [CNT_W-1:0] C_UNO   = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_DOS   = CNT_W'(2);
    localparam logic [CNT_W-1:0] C_LLENO = CNT_W'(DEPTH);

    logic [CNT_W-1:0] r_ocup;
    logic [DATA-1:0]  r_salida;
    logic             r_vacia;
    logic             r_llena;
    logic             r_err_desb;
    logic             r_err_sub;

    logic [1:0]       w_op;
    logic [CNT_W-1:0] w_ocup_next;
    logic [DATA-1:0]  w_salida_next;
    logic             w_we;
    logic [AW-1:0]    w_waddr;
    logic             w_set_desb;
    logic             w_set_sub;
    logic [DATA-1:0]  w_sub;
    // Top-entry read port is kept for future consumers; the registered output
    // already mirrors the top, so nothing reads it today.
    logic [DATA-1:0]  w_top_unused;

    assign w_op = {push, pop};

    pila_mem #(
        .DATA  (DATA),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk         (clk),
        .i_we        (w_we & ~reset),
        .i_waddr     (w_waddr),
        .i_wdata     (entradaDatos),
        .i_raddr_top (AW'(r_ocup - C_UNO)),
        .i_raddr_sub (AW'(r_ocup - C_DOS)),
        .o_top       (w_top_unused),
        .o_sub       (w_sub)
    );

    // Next-state decode. r_vacia/r_llena are exact decodes of r_ocup, so they
    // serve directly as the "currently empty/full" guards.
    // NOTE: every signal gets a default at the top of the block so no path
    // leaves it unassigned, which is what keeps this free of latches.
    always_comb begin
        w_ocup_next   = r_ocup;
        w_salida_next = r_salida;
        w_we          = 1'b0;
        w_waddr       = AW'(r_ocup);
        w_set_desb    = 1'b0;
        w_set_sub     = 1'b0;
        if (activa) begin
            case (w_op)
                OP_PUSH: begin
                    if (!r_llena) begin
                        w_we          = 1'b1;
                        w_ocup_next   = r_ocup + C_UNO;
                        w_salida_next = entradaDatos;
                    end else begin
                        w_set_desb = 1'b1;
                    end
                end
                OP_POP: begin
                    if (!r_vacia) begin
                        w_ocup_next   = r_ocup - C_UNO;
                        // Popping the last entry exposes an empty stack.
                        w_salida_next = (r_ocup == C_UNO) ? '0 : w_sub;
                    end else begin
                        w_set_sub = 1'b1;
                    end
                end
                OP_REEMPLAZA: begin
                    // Overwrite the top; on an empty stack this is a push.
                    w_we          = 1'b1;
                    w_salida_next = entradaDatos;
                    if (r_vacia) begin
                        w_ocup_next = C_UNO;
                    end else begin
                        w_waddr = AW'(r_ocup - C_UNO);
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: non-blocking assignments for all state so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ocup     <= '0;
            r_salida   <= '0;
            r_vacia    <= 1'b1;
            r_llena    <= 1'b0;
            r_err_desb <= 1'b0;
            r_err_sub  <= 1'b0;
        end else begin
            r_ocup     <= w_ocup_next;
            r_salida   <= w_salida_next;
            r_vacia    <= (w_ocup_next == '0);
            r_llena    <= (w_ocup_next == C_LLENO);
            // Set has priority over clear.
            r_err_desb <= w_set_desb | (r_err_desb & ~limpia_error);
            r_err_sub  <= w_set_sub  | (r_err_sub  & ~limpia_error);
        end
    end

    assign salidaDatos     = r_salida;
    assign ocupacion       = r_ocup;
    assign vacia           = r_vacia;
    assign llena           = r_llena;
    assign err_desborde    = r_err_desb;
    assign err_subdesborde = r_err_sub;

endmodule

// File: tb/tb_pila_parametrica.sv
// ---------------------------------------------------------------------------
// tb_pila_parametrica
//   Self-checking bench for pila_parametrica (DATA=8, DEPTH=4): directed
//   scenarios against literal expectations, then random traffic against a
//   queue-based model of the stack.
// ---------------------------------------------------------------------------
module tb_pila_parametrica;

    localparam int DATA  = 8;
    localparam int DEPTH = 4;

    logic            clk;
    logic            reset;
    logic            activa;
    logic            push;
    logic            pop;
    logic            limpia_error;
    logic [DATA-1:0] entradaDatos;
    logic [DATA-1:0] salidaDatos;
    logic [2:0]      ocupacion;
    logic            vacia;
    logic            llena;
    logic            err_desborde;
    logic            err_subdesborde;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: a queue whose back is the top of stack.
    logic [DATA-1:0] q[$];
    bit              m_ov;
    bit              m_un;

    pila_parametrica #(
        .DATA  (DATA),
        .DEPTH (DEPTH)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .activa          (activa),
        .push            (push),
        .pop             (pop),
        .limpia_error    (limpia_error),
        .entradaDatos    (entradaDatos),
        .salidaDatos     (salidaDatos),
        .ocupacion       (ocupacion),
        .vacia           (vacia),
        .llena           (llena),
        .err_desborde    (err_desborde),
        .err_subdesborde (err_subdesborde)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle, advance the model by the same operation, sample #1
    // after the edge.
    task automatic step(input logic r, input logic a, input logic p,
                        input logic o, input logic c, input logic [DATA-1:0] d);
        bit set_ov;
        bit set_un;
        reset = r; activa = a; push = p; pop = o; limpia_error = c; entradaDatos = d;
        @(posedge clk);
        set_ov = 1'b0;
        set_un = 1'b0;
        if (r) begin
            q.delete();
            m_ov = 1'b0;
            m_un = 1'b0;
        end else begin
            if (a) begin
                if (p && !o) begin
                    if (q.size() < DEPTH) q.push_back(d);
                    else set_ov = 1'b1;
                end else if (!p && o) begin
                    if (q.size() > 0) void'(q.pop_back());
                    else set_un = 1'b1;
                end else if (p && o) begin
                    if (q.size() > 0) q[q.size()-1] = d;
                    else q.push_back(d);
                end
            end
            m_ov = set_ov || (m_ov && !c);
            m_un = set_un || (m_un && !c);
        end
        #1;
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0, 0, 8'h00);
        n_total++; if (ocupacion !== 3'd0) $display("FAIL rst_ocup: got %0d want 0", ocupacion); else n_pass++;
        n_total++; if (salidaDatos !== 8'h00) $display("FAIL rst_top: got %0h want 0", salidaDatos); else n_pass++;
        n_total++; if (vacia !== 1'b1) $display("FAIL rst_vacia: got %b want 1", vacia); else n_pass++;
        n_total++; if (llena !== 1'b0) $display("FAIL rst_llena: got %b want 0", llena); else n_pass++;
        n_total++; if ({err_desborde, err_subdesborde} !== 2'b00)
            $display("FAIL rst_err: got %b want 00", {err_desborde, err_subdesborde}); else n_pass++;
    endtask

    task automatic test_push_fill();
        logic [DATA-1:0] vals [3] = '{8'h11, 8'h22, 8'h33};
        foreach (vals[i]) begin
            step(0, 1, 1, 0, 0, vals[i]);
            n_total++; if (salidaDatos !== vals[i])
                $display("FAIL push_top%0d: got %0h want %0h", i, salidaDatos, vals[i]); else n_pass++;
        end
        n_total++; if (ocupacion !== 3'd3) $display("FAIL push_ocup3: got %0d want 3", ocupacion); else n_pass++;
        n_total++; if ({vacia, llena} !== 2'b00) $display("FAIL push_flags3: got %b want 00", {vacia, llena}); else n_pass++;
        step(0, 1, 1, 0, 0, 8'h44);
        n_total++; if (llena !== 1'b1) $display("FAIL full_llena: got %b want 1", llena); else n_pass++;
        n_total++; if (ocupacion !== 3'd4) $display("FAIL full_ocup: got %0d want 4", ocupacion); else n_pass++;
        n_total++; if (err_desborde !== 1'b0) $display("FAIL full_noerr: got %b want 0", err_desborde); else n_pass++;
        step(0, 1, 1, 0, 0, 8'h55);
        n_total++; if (err_desborde !== 1'b1) $display("FAIL ovf_err: got %b want 1", err_desborde); else n_pass++;
        n_total++; if (salidaDatos !== 8'h44) $display("FAIL ovf_top: got %0h want 44", salidaDatos); else n_pass++;
        n_total++; if (ocupacion !== 3'd4) $display("FAIL ovf_ocup: got %0d want 4", ocupacion); else n_pass++;
    endtask

    task automatic test_pop_drain();
        logic [DATA-1:0] vals [4] = '{8'h33, 8'h22, 8'h11, 8'h00};
        foreach (vals[i]) begin
            step(0, 1, 0, 1, 0, 8'hEE);
            n_total++; if (salidaDatos !== vals[i])
                $display("FAIL pop_top%0d: got %0h want %0h", i, salidaDatos, vals[i]); else n_pass++;
        end
        n_total++; if (vacia !== 1'b1) $display("FAIL drain_vacia: got %b want 1", vacia); else n_pass++;
        n_total++; if (err_subdesborde !== 1'b0) $display("FAIL drain_noerr: got %b want 0", err_subdesborde); else n_pass++;
        step(0, 1, 0, 1, 0, 8'hEE);
        n_total++; if (err_subdesborde !== 1'b1) $display("FAIL udf_err: got %b want 1", err_subdesborde); else n_pass++;
        n_total++; if (ocupacion !== 3'd0) $display("FAIL udf_ocup: got %0d want 0", ocupacion); else n_pass++;
    endtask

    task automatic test_replace();
        step(0, 0, 0, 0, 1, 8'h00);
        n_total++; if ({err_desborde, err_subdesborde} !== 2'b00)
            $display("FAIL clr_err: got %b want 00", {err_desborde, err_subdesborde}); else n_pass++;
        for (int i = 0; i < DEPTH; i++) step(0, 1, 1, 0, 0, 8'hA1 + 8'(i));
        step(0, 1, 1, 1, 0, 8'h99);
        n_total++; if (ocupacion !== 3'd4) $display("FAIL rep_full_ocup: got %0d want 4", ocupacion); else n_pass++;
        n_total++; if (salidaDatos !== 8'h99) $display("FAIL rep_full_top: got %0h want 99", salidaDatos); else n_pass++;
        n_total++; if (err_desborde !== 1'b0) $display("FAIL rep_full_err: got %b want 0", err_desborde); else n_pass++;
        step(0, 1, 0, 1, 0, 8'h00);
        n_total++; if (salidaDatos !== 8'hA3) $display("FAIL rep_below: got %0h want a3", salidaDatos); else n_pass++;
        for (int i = 0; i < 3; i++) step(0, 1, 0, 1, 0, 8'h00);
        step(0, 1, 1, 1, 0, 8'h77);
        n_total++; if (ocupacion !== 3'd1) $display("FAIL rep_empty_ocup: got %0d want 1", ocupacion); else n_pass++;
        n_total++; if (salidaDatos !== 8'h77) $display("FAIL rep_empty_top: got %0h want 77", salidaDatos); else n_pass++;
        n_total++; if (err_subdesborde !== 1'b0) $display("FAIL rep_empty_err: got %b want 0", err_subdesborde); else n_pass++;
    endtask

    task automatic test_hold_and_clear();
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 1, 0, 8'($urandom));
            n_total++; if (ocupacion !== 3'd1) $display("FAIL hold_ocup%0d: got %0d want 1", i, ocupacion); else n_pass++;
            n_total++; if (salidaDatos !== 8'h77) $display("FAIL hold_top%0d: got %0h want 77", i, salidaDatos); else n_pass++;
            n_total++; if ({vacia, llena, err_desborde, err_subdesborde} !== 4'b0000)
                $display("FAIL hold_flags%0d: got %b want 0000", i, {vacia, llena, err_desborde, err_subdesborde}); else n_pass++;
        end
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0, 8'hB1 + 8'(i));
        step(0, 1, 1, 0, 1, 8'hCC);
        n_total++; if (err_desborde !== 1'b1) $display("FAIL setwins_err: got %b want 1", err_desborde); else n_pass++;
        n_total++; if (salidaDatos !== 8'hB3) $display("FAIL setwins_top: got %0h want b3", salidaDatos); else n_pass++;
        step(0, 1, 0, 0, 1, 8'h00);
        n_total++; if (err_desborde !== 1'b0) $display("FAIL clear_err: got %b want 0", err_desborde); else n_pass++;
        n_total++; if (ocupacion !== 3'd4) $display("FAIL clear_ocup: got %0d want 4", ocupacion); else n_pass++;
    endtask

    task automatic test_reset_mid();
        step(1, 0, 0, 0, 0, 8'h00);
        step(0, 1, 0, 1, 0, 8'h00);
        for (int i = 0; i < DEPTH; i++) step(0, 1, 1, 0, 0, 8'hC0 + 8'(i));
        step(0, 1, 1, 0, 0, 8'hFF);
        step(0, 1, 0, 1, 0, 8'h00);
        step(0, 1, 0, 1, 0, 8'h00);
        n_total++; if ({ocupacion, err_desborde, err_subdesborde} !== {3'd2, 2'b11})
            $display("FAIL mid_pre: got %0d/%b want 2/11", ocupacion, {err_desborde, err_subdesborde}); else n_pass++;
        step(1, 1, 1, 0, 0, 8'h3C);
        n_total++; if ({ocupacion, salidaDatos} !== {3'd0, 8'h00})
            $display("FAIL mid_rst: got %0d/%0h want 0/0", ocupacion, salidaDatos); else n_pass++;
        n_total++; if ({vacia, llena, err_desborde, err_subdesborde} !== 4'b1000)
            $display("FAIL mid_rst_flags: got %b want 1000", {vacia, llena, err_desborde, err_subdesborde}); else n_pass++;
        step(0, 1, 1, 0, 0, 8'hA5);
        step(0, 1, 1, 0, 0, 8'h5A);
        step(0, 1, 0, 1, 0, 8'h00);
        n_total++; if ({ocupacion, salidaDatos} !== {3'd1, 8'hA5})
            $display("FAIL mid_entry0: got %0d/%0h want 1/a5", ocupacion, salidaDatos); else n_pass++;
    endtask

    task automatic test_random();
        logic [DATA-1:0] exp_top;
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(49) == 0), ($urandom_range(7) != 0), 1'($urandom), 1'($urandom),
                 ($urandom_range(15) == 0), 8'($urandom));
            exp_top = (q.size() != 0) ? q[q.size()-1] : 8'h00;
            n_total++; if (salidaDatos !== exp_top)
                $display("FAIL rnd_top@%0d: got %0h want %0h", i, salidaDatos, exp_top); else n_pass++;
            n_total++; if (ocupacion !== 3'(q.size()))
                $display("FAIL rnd_ocup@%0d: got %0d want %0d", i, ocupacion, q.size()); else n_pass++;
            n_total++; if ({vacia, llena} !== {(q.size() == 0), (q.size() == DEPTH)})
                $display("FAIL rnd_flags@%0d: got %b want %b", i, {vacia, llena},
                         {(q.size() == 0), (q.size() == DEPTH)}); else n_pass++;
            n_total++; if ({err_desborde, err_subdesborde} !== {m_ov, m_un})
                $display("FAIL rnd_err@%0d: got %b want %b", i, {err_desborde, err_subdesborde}, {m_ov, m_un}); else n_pass++;
        end
    endtask

    initial begin
        reset = 1'b1; activa = 1'b0; push = 1'b0; pop = 1'b0;
        limpia_error = 1'b0; entradaDatos = '0;
        m_ov = 1'b0; m_un = 1'b0;
        test_reset();
        test_push_fill();
        test_pop_drain();
        test_replace();
        test_hold_and_clear();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
